multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles.
- Drives the datapath selects, write enables, the immediate-format select for the immediate extender, and the ALU operation.
- Sits between the instruction register (opcode/funct fields) plus the ALU zero flag and the datapath muxes and enables.

---
 rtl/riscv_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 144 ++++++++++++++
 tb/tb_multicycle_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [ALUCTL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [SEL_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [SEL_W-1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_src_e;

    typedef enum logic [SEL_W-1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [SEL_W-1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [SEL_W-1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    // funct3 values the ALU decoder implements for R-type and I-ALU
    function automatic logic alu_funct3_legal(input logic [FUNCT3_W-1:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b010) ||
               (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    function automatic logic branch_funct3_legal(input logic [FUNCT3_W-1:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields in, datapath controls out, between the controller and the datapath.
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic [OP_W-1:0]     i_Op;
    logic [FUNCT3_W-1:0] i_Funct3;
    logic                i_Funct7b5;
    logic                i_Zero;
    logic                o_PCWrite;
    logic                o_AdrSrc;
    logic                o_MemWrite;
    logic                o_IRWrite;
    logic                o_RegWrite;
    logic [SEL_W-1:0]    o_ResultSrc;
    logic [SEL_W-1:0]    o_ALUSrcA;
    logic [SEL_W-1:0]    o_ALUSrcB;
    logic [SEL_W-1:0]    o_ImmSrc;
    logic [ALUCTL_W-1:0] o_ALUControl;
    logic                o_Illegal;
    logic [STATE_W-1:0]  o_State;

    modport master (
        input  i_Op, i_Funct3, i_Funct7b5, i_Zero,
        output o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
               o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl,
               o_Illegal, o_State
    );

    modport slave (
        output i_Op, i_Funct3, i_Funct7b5, i_Zero,
        input  o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
               o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl,
               o_Illegal, o_State
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALUOp plus funct fields to the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0]    alu_op,
    input  logic [FUNCT3_W-1:0] i_Funct3,
    input  logic                i_Funct7b5,
    input  logic                is_rtype,
    output logic [ALUCTL_W-1:0] o_ALUControl
);

    always_comb begin
        o_ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: o_ALUControl = ALU_ADD;
            ALUOP_SUB: o_ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_Funct3)
                    // addi has no subtract form, so bit 30 only matters for R-type
                    3'b000:  o_ALUControl = (is_rtype && i_Funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_ALUControl = ALU_SLT;
                    3'b110:  o_ALUControl = ALU_OR;
                    3'b111:  o_ALUControl = ALU_AND;
                    default: o_ALUControl = ALU_ADD;
                endcase
            end
            default: o_ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; outputs decode from the state register.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Reset,
    multicycle_controller_if.master bus
);

    state_e           state;
    state_e           next_state;
    logic [SEL_W-1:0] alu_op;
    logic             is_rtype;
    logic             is_lw;
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             illegal;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] imm_src;
    state_e           bad_dest;

    assign is_rtype = (bus.i_Op == OP_RTYPE);
    assign is_lw    = (bus.i_Op == OP_LW);
    assign bad_dest = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) state <= S_FETCH;
        else         state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;

        if (i_Reset) begin
            // FETCH selects with every write enable held off
            result_src = RES_ALURESULT;
            alu_src_b  = SRCB_FOUR;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    next_state = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    case (bus.i_Op)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_RTYPE:  next_state = alu_funct3_legal(bus.i_Funct3) ? S_EXECUTER : bad_dest;
                        OP_IALU:   next_state = alu_funct3_legal(bus.i_Funct3) ? S_EXECUTEI : bad_dest;
                        OP_BRANCH: next_state = branch_funct3_legal(bus.i_Funct3) ? S_BRANCH : bad_dest;
                        default:   next_state = bad_dest;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = is_lw ? IMM_I : IMM_S;
                    next_state = is_lw ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    adr_src    = 1'b1;
                    next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    alu_src_a  = SRCA_RS1;
                    alu_op     = ALUOP_FUNCT;
                    next_state = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = ALUOP_FUNCT;
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_write  = ((bus.i_Funct3 == 3'b000) &&  bus.i_Zero) ||
                                ((bus.i_Funct3 == 3'b001) && !bus.i_Zero);
                end
                S_ILLEGAL: begin
                    illegal    = 1'b1;
                    next_state = S_ILLEGAL;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op       (alu_op),
        .i_Funct3     (bus.i_Funct3),
        .i_Funct7b5   (bus.i_Funct7b5),
        .is_rtype     (is_rtype),
        .o_ALUControl (bus.o_ALUControl)
    );

    assign bus.o_PCWrite   = pc_write;
    assign bus.o_AdrSrc    = adr_src;
    assign bus.o_MemWrite  = mem_write;
    assign bus.o_IRWrite   = ir_write;
    assign bus.o_RegWrite  = reg_write;
    assign bus.o_ResultSrc = result_src;
    assign bus.o_ALUSrcA   = alu_src_a;
    assign bus.o_ALUSrcB   = alu_src_b;
    assign bus.o_ImmSrc    = imm_src;
    assign bus.o_Illegal   = illegal;
    assign bus.o_State     = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: walks each instruction class through the FSM and checks every control output per cycle.
module tb_multicycle_controller;

    logic i_Clk = 1'b0;
    logic i_Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_controller_if dif ();

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (dif)
    );

    always #5 i_Clk = ~i_Clk;

    // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal}
    function automatic logic [20:0] v(input int st, input int pcw, input int adr, input int mw,
                                      input int irw, input int rw, input int rs, input int sa,
                                      input int sb, input int imm, input int alu, input int ill);
        return {4'(st), 1'(pcw), 1'(adr), 1'(mw), 1'(irw), 1'(rw),
                2'(rs), 2'(sa), 2'(sb), 2'(imm), 3'(alu), 1'(ill)};
    endfunction

    function automatic logic [20:0] observed();
        return {dif.o_State, dif.o_PCWrite, dif.o_AdrSrc, dif.o_MemWrite, dif.o_IRWrite,
                dif.o_RegWrite, dif.o_ResultSrc, dif.o_ALUSrcA, dif.o_ALUSrcB, dif.o_ImmSrc,
                dif.o_ALUControl, dif.o_Illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #2;
    endtask

    logic [20:0] exp_q[$];

    // Checks exp_q one entry per cycle, starting in the current cycle; leaves the bench on the last one.
    task automatic run_seq(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            check($sformatf("%s.c%0d", name, i), 32'(observed()), 32'(exp_q[i]));
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        dif.i_Op       = op;
        dif.i_Funct3   = f3;
        dif.i_Funct7b5 = f7;
        dif.i_Zero     = z;
        #1;
    endtask

    logic [20:0] F, D, RST;

    initial begin
        F   = v(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0);
        D   = v(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
        RST = v(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);

        i_Reset = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        check("rst.state", 32'(dif.o_State), 32'd0);
        check("rst.enables", 32'({dif.o_PCWrite, dif.o_IRWrite, dif.o_MemWrite, dif.o_RegWrite}), 32'd0);
        check("rst.vec", 32'(observed()), 32'(RST));

        i_Reset = 1'b0;
        #1;
        check("rst.rel_pcw", 32'(dif.o_PCWrite), 32'd1);
        check("rst.rel_irw", 32'(dif.o_IRWrite), 32'd1);
        check("rst.rel_srcb", 32'(dif.o_ALUSrcB), 32'd2);

        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        exp_q = '{F, D, v(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), v(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                  v(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), F};
        run_seq("lw");

        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        exp_q = '{F, D, v(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0), v(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), F};
        run_seq("sw");

        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        exp_q = '{F, D, v(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0), v(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), F};
        run_seq("rsub");

        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        exp_q = '{F, D, v(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), v(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), F};
        run_seq("addi");

        set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
        exp_q = '{F, D, v(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0), v(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), F};
        run_seq("rand");

        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        exp_q = '{F, D, v(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 5, 0), v(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), F};
        run_seq("rslt");

        set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
        exp_q = '{F, D, v(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 3, 0), v(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), F};
        run_seq("ori");

        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        exp_q = '{F, D, v(9, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0), F};
        run_seq("beq_taken");

        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        exp_q = '{F, D, v(9, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0), F};
        run_seq("bne_not");

        set_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
        exp_q = '{F, D, v(9, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0), F};
        run_seq("bne_taken");

        // Unsupported opcode locks the FSM until reset
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        exp_q = '{F, D};
        for (int i = 0; i < 10; i++) exp_q.push_back(v(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run_seq("illop");

        i_Reset = 1'b1;
        #1;
        check("ill.rst_vec", 32'(observed()), 32'(v(10, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0)));
        tick();
        i_Reset = 1'b0;
        #1;

        // Branch with an unsupported funct3 is also illegal
        set_instr(7'b1100011, 3'b010, 1'b0, 1'b0);
        exp_q = '{F, D, v(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), v(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        run_seq("illf3");

        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        #1;

        // Reset in MEMREAD aborts the load before its writeback
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        exp_q = '{F, D, v(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), v(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        run_seq("abort");
        i_Reset = 1'b1;
        #1;
        check("abort.rst_vec", 32'(observed()), 32'(v(3, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0)));
        tick();
        i_Reset = 1'b0;
        #1;
        check("abort.next", 32'(observed()), 32'(F));
        check("abort.no_rw", 32'(dif.o_RegWrite), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
